// File: rtl/nn_mem_pkg.sv
// Shared constants and encodings for the parameter-memory read path.
// Base addresses locate each layer's blob inside the parameter BRAM.
package nn_mem_pkg;

    localparam int RD_LAT         = 2;
    localparam int DEF_W          = 8;
    localparam int DEF_ADDR_WIDTH = 18;

    localparam int L1_WEIGHT_BASE = 0;
    localparam int L1_BIAS_BASE   = 147464;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ZERO  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/bram.sv
// Single-port parameter BRAM with a two-stage registered read path.
// An address presented in cycle c appears on dout in cycle c+2.
module bram #(
    parameter int W  = 8,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          en,
    input  logic          ren,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_q;
    logic [W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) mem[addr] <= din;
            if (ren) rd_q <= mem[addr];
            dout_q <= rd_q;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last winner.
// Reusable by any shared-resource arbiter.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] id,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        id  = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(last) + i) % N);
            if (!any && req[j]) begin
                any = 1'b1;
                id  = j;
            end
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin burst reader sharing one parameter BRAM among loaders.
// Words return tagged with owner id and index; done marks the last word.
module bram_read_arbiter
    import nn_mem_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int W          = DEF_W,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = 19,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rd_valid,
    output logic [ID_W-1:0]               rd_id,
    output logic [LEN_WIDTH-1:0]          rd_index,
    output logic [W-1:0]                  rd_data,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy
);

    localparam int DCW = $clog2(RD_LAT + 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  k_q, k_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;

    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [RD_LAT-1:0]     lst_q, lst_d;
    logic [LEN_WIDTH-1:0]  idx_q [RD_LAT];
    logic [LEN_WIDTH-1:0]  idx_d [RD_LAT];
    logic [ID_W-1:0]       pid_q [RD_LAT];
    logic [ID_W-1:0]       pid_d [RD_LAT];

    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;
    logic                  issue;
    logic                  last_k;
    logic                  bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .id   (pick_id),
        .any  (pick_any)
    );

    assign issue     = (state_q == ISSUE);
    assign bram_en   = issue || (state_q == DRAIN);
    assign last_k    = (k_q == len_q - LEN_WIDTH'(1));
    assign bram_addr = base_q + k_q[ADDR_WIDTH-1:0];

    bram #(
        .W  (W),
        .AW (ADDR_WIDTH)
    ) u_bram (
        .clk  (clk),
        .en   (bram_en),
        .ren  (issue),
        .wen  (1'b0),
        .addr (bram_addr),
        .din  ({W{1'b0}}),
        .dout (rd_data)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        k_d     = k_q;
        id_d    = id_q;
        last_d  = last_q;
        dcnt_d  = dcnt_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (pick_id == ID_W'(i));
                        if (pick_id == ID_W'(i)) begin
                            base_d = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                            len_d  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
                        end
                    end
                    id_d    = pick_id;
                    last_d  = pick_id;
                    k_d     = '0;
                    state_d = (len_d == '0) ? ZERO : ISSUE;
                end
            end
            ISSUE: begin
                k_d = k_q + LEN_WIDTH'(1);
                if (last_k) begin
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DCW'(1);
                if (dcnt_q == DCW'(RD_LAT - 1)) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ZERO: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Tag pipeline tracks each issued address through the BRAM latency.
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = issue;
        lst_d[0] = issue && last_k;
        idx_d[0] = k_q;
        pid_d[0] = id_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
            idx_d[i] = idx_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            id_q    <= '0;
            last_q  <= LAST_RST;
            dcnt_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= '0;
                pid_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
            id_q    <= id_d;
            last_q  <= last_d;
            dcnt_q  <= dcnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= idx_d[i];
                pid_q[i] <= pid_d[i];
            end
        end
    end

    always_comb begin
        done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lst_q[RD_LAT-1] && pid_q[RD_LAT-1] == ID_W'(i)) done[i] = 1'b1;
            if (state_q == ZERO && id_q == ID_W'(i)) done[i] = 1'b1;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign rd_valid = vld_q[RD_LAT-1];
    assign rd_id    = pid_q[RD_LAT-1];
    assign rd_index = idx_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed plus randomized checks of the shared BRAM burst reader
// against a job-level round-robin and memory-content model.
module tb_bram_read_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int AW  = 18;
    localparam int LW  = 19;
    localparam int IDW = 2;

    localparam logic [N*AW-1:0] BMASK = {{((N-1)*AW){1'b0}}, {AW{1'b1}}};
    localparam logic [N*LW-1:0] LMASK = {{((N-1)*LW){1'b0}}, {LW{1'b1}}};

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_base;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic            rd_valid;
    logic [IDW-1:0]  rd_id;
    logic [LW-1:0]   rd_index;
    logic [W-1:0]    rd_data;
    logic [N-1:0]    done;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int last_w;
    int jb_base [N];
    int jb_len  [N];

    always #5 clk = ~clk;

    bram_read_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_base (req_base),
        .req_len  (req_len),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_index (rd_index),
        .rd_data  (rd_data),
        .done     (done),
        .busy     (busy)
    );

    function automatic logic [7:0] mem_val(input int a);
        logic [7:0] lo;
        lo = 8'(a);
        return lo ^ 8'h5A;
    endfunction

    // Next owner: first pending client after the previous winner.
    function automatic int rr_next(input int last, input logic [N-1:0] pend);
        int j;
        for (int i = 1; i <= N; i++) begin
            j = (last + i) % N;
            if (((pend >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int c, input int base, input int len);
        jb_base[c] = base;
        jb_len[c]  = len;
        req_base = (req_base & ~(BMASK << (c * AW)))
                 | ((N*AW)'(AW'(base)) << (c * AW));
        req_len  = (req_len & ~(LMASK << (c * LW)))
                 | ((N*LW)'(LW'(len)) << (c * LW));
    endtask

    task automatic check_job(input int id, input int base, input int len,
                             input bit drop);
        int n;
        logic [N-1:0] eg;
        eg = N'(1) << id;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == '0 && n < 40);
        chk($sformatf("gnt_wait c%0d", id), n, 1);
        if (len == 0) begin
            chk($sformatf("z_gnt c%0d", id), 32'(gnt), 32'(eg));
            chk($sformatf("z_done c%0d", id), 32'(done), 32'(eg));
            chk($sformatf("z_valid c%0d", id), 32'(rd_valid), 0);
            chk($sformatf("z_busy c%0d", id), 32'(busy), 1);
            if (drop) req = req & ~eg;
        end else begin
            for (int t = 1; t <= len + 2; t++) begin
                if (t > 1) step();
                chk($sformatf("gnt c%0d t%0d", id, t), 32'(gnt), 32'(eg));
                chk($sformatf("busy c%0d t%0d", id, t), 32'(busy), 1);
                chk($sformatf("valid c%0d t%0d", id, t),
                    32'(rd_valid), 32'(t >= 3));
                chk($sformatf("done c%0d t%0d", id, t), 32'(done),
                    (t == len + 2) ? 32'(eg) : 32'(0));
                if (t >= 3) begin
                    chk($sformatf("index c%0d t%0d", id, t),
                        32'(rd_index), t - 3);
                    chk($sformatf("id c%0d t%0d", id, t), 32'(rd_id), id);
                    chk($sformatf("data c%0d t%0d", id, t), 32'(rd_data),
                        32'(mem_val((base + t - 3) % (2**AW))));
                end
                if (t == len + 2 && drop) req = req & ~eg;
            end
        end
        step();
        chk($sformatf("end_gnt c%0d", id), 32'(gnt), 0);
        chk($sformatf("end_busy c%0d", id), 32'(busy), 0);
        chk($sformatf("end_valid c%0d", id), 32'(rd_valid), 0);
        chk($sformatf("end_done c%0d", id), 32'(done), 0);
    endtask

    task automatic run_batch(input logic [N-1:0] pend_in);
        logic [N-1:0] pend;
        int w;
        pend = pend_in;
        req = pend;
        for (int j = 0; j < N && pend != '0; j++) begin
            w = rr_next(last_w, pend);
            check_job(w, jb_base[w], jb_len[w], 1'b1);
            pend = pend & ~(N'(1) << w);
            last_w = w;
        end
    endtask

    initial begin
        logic [AW-1:0] ad;
        logic [N-1:0] pend;
        int w;
        int n;

        rst = 1'b1;
        req = '0;
        req_base = '0;
        req_len = '0;
        for (int a = 0; a < 2**AW; a++) begin
            ad = AW'(a);
            dut.u_bram.mem[ad] = mem_val(a);
        end

        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_id", 32'(rd_id), 0);
        chk("rst_index", 32'(rd_index), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        last_w = N - 1;
        step();

        set_client(1, 147464, 8);
        run_batch(4'b0010);

        rst = 1'b1;
        step();
        rst = 1'b0;
        last_w = N - 1;
        for (int c = 0; c < N; c++) set_client(c, 100 * (c + 1), 3);
        run_batch(4'b1111);

        // Clients 0 and 2 hold req across two rounds.
        set_client(0, 500, 2);
        set_client(2, 700, 2);
        pend = 4'b0101;
        req = pend;
        for (int j = 0; j < 4; j++) begin
            w = rr_next(last_w, pend);
            check_job(w, jb_base[w], jb_len[w], j >= 2);
            if (j >= 2) pend = pend & ~(N'(1) << w);
            last_w = w;
        end

        set_client(3, 2**AW - 2, 4);
        run_batch(4'b1000);
        set_client(2, 5, 0);
        run_batch(4'b0100);

        for (int b = 0; b < 6; b++) begin
            pend = N'($urandom_range(1, 2**N - 1));
            for (int c = 0; c < N; c++)
                set_client(c, int'($urandom_range(0, 2**AW - 1)),
                           int'($urandom_range(0, 6)));
            run_batch(pend);
        end

        set_client(1, 1000, 8);
        req = 4'b0010;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == '0 && n < 40);
        chk("abort_gnt", 32'(gnt), 32'(4'b0010));
        repeat (4) step();
        chk("abort_valid3", 32'(rd_valid), 1);
        chk("abort_index3", 32'(rd_index), 2);
        chk("abort_data3", 32'(rd_data), 32'(mem_val(1002)));
        rst = 1'b1;
        req = '0;
        step();
        chk("abort_rd_valid", 32'(rd_valid), 0);
        chk("abort_gnt_clr", 32'(gnt), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        rst = 1'b0;
        last_w = N - 1;
        set_client(3, 50, 2);
        run_batch(4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
